prim_fifo_sync_cnt_rw: RTL and testbench
========================================

# prim_fifo_sync_cnt_rw

Pointer and occupancy controller for synchronous FIFOs with arbitrary (non-power-of-two) depth, runtime watermarks, sticky overflow/underflow detection and optional checkpointed read (commit/rewind). The entry storage instantiates it in place of the plain pointer counter when a consumer may need to re-read data, for example UART TX retransmit. It adds watermark flags so producers and consumers can throttle early.

## Interface
- `Depth`, default 4: number of entries, must be at least 2. Any integer is allowed.
- `NeverClears`, default 0: when 1, `clr_i` is ignored and the clear logic is removed.
- `PtrW` (localparam): `vbits(Depth)`.
- `DepthW` (localparam): `vbits(Depth+1)`.
- `clk_i`  in  1  clock. This is the only clock.
- `rst_ni`  in  1  reset, synchronous and active-low, sampled on the `clk_i` rising edge.
- `clr_i`  in  1  synchronous flush of all pointers and error flags.
- `incr_wptr_i`  in  1  write request.
- `incr_rptr_i`  in  1  read request.
- `commit_i`  in  1  release read entries up to the read pointer.
- `rewind_i`  in  1  restore the read pointer to the last commit.
- `ae_thresh_i`  in  DepthW  almost-empty threshold.
- `af_thresh_i`  in  DepthW  almost-full threshold.
- `wptr_o`, `rptr_o`  out  PtrW  storage indices, range 0..Depth-1.
- `depth_o`  out  DepthW  readable entries, equal to wptr minus rptr.
- `used_o`  out  DepthW  occupied entries, equal to wptr minus cptr.
- `full_o`, `empty_o`, `almost_full_o`, `almost_empty_o`  out  1  status flags.
- `wr_ack_o`, `rd_ack_o`  out  1  request accepted this cycle (combinational).
- `err_o`  out  1  sticky OR of overflow and underflow.

## Operation
- Three wrap pointers `w`, `r` and `c`, each PtrW+1 bits. The MSB toggles on wrap.
- Increment rule: a pointer whose low part equals Depth-1 loads `{~msb, 0}`. Otherwise it increments by 1.
- Occupancy from pointers `a` and `b`:
  - if `a.msb == b.msb`: `a.low - b.low`;
  - otherwise: `Depth - b.low + a.low`.
  - All arithmetic is DepthW bits.
- `depth_o` is occupancy(w, r). `used_o` is occupancy(w, c).
- `empty_o` is set when `w == r`.
- `full_o` is set when `w == c ^ {1, 0...}`.
- `almost_full_o` is set when `used_o >= af_thresh_i`.
- `almost_empty_o` is set when `depth_o <= ae_thresh_i`.
- Write acceptance: accepted when `!full_o`. Otherwise the write is dropped, `wptr` holds and the sticky `ovf` flag is set.
- Read acceptance: accepted when `!empty_o` and `!rewind_i`. If empty, the read is dropped and the sticky `udf` flag is set. A read dropped because of `rewind_i` sets no flag.
- Simultaneous read and write are allowed, judged on the pre-edge flags:
  - when full, the read is accepted and the write is dropped with `ovf` set;
  - when empty, the write is accepted and the read is dropped with `udf` set.
- Commit: `c <= r_next`, where `r_next` includes a read accepted in the same cycle.
- Rewind: `r <= c`. Rewind has priority over commit; a commit in the same cycle is ignored.
- Control priority: `rst_ni` low, then `clr_i`, then the per-pointer update.
- `clr_i`: all pointers return to 0 and `ovf`/`udf` are cleared.
- `err_o` is `ovf | udf`.

## Timing
- Reset (`rst_ni` low at an edge):
  - pointers are 0 and error flags clear;
  - `empty_o=1`, `full_o=0`, `depth_o=0`, `used_o=0`, `err_o=0`;
  - `almost_empty_o=1`, and `almost_full_o=(af_thresh_i==0)`.
  - Reset asserted mid-operation discards all state at that edge. Requests in that cycle are lost, and the ack outputs are forced to 0 while `rst_ni` is low.
- All state is registered. Flags and counts are combinational from registers and reflect a strobe in the cycle after it.
- Latency: write to visible `!empty_o` is 1 cycle. Read to freed space is 1 cycle with the feature off, and 1 cycle after `commit_i` with it on.
- Acks are combinational from current-cycle inputs and pre-edge flags.

## Configuration
- `PRIM_FIFO_CNT_REWIND_EN` defined:
  - the `c` register exists;
  - `commit_i` and `rewind_i` behave as described in Operation.
- Not defined:
  - `c` is a wire equal to `r`, so `used_o` equals `depth_o` and space frees on every read;
  - `commit_i` and `rewind_i` are ignored, and reads are never blocked by `rewind_i`.
- The port list is identical in both builds.

## Structure
- Package `prim_fifo_cnt_pkg` holds:
  - the `occupancy` function, parameterised by width and depth through its arguments;
  - the error-cause typedef `{ovf, udf}`.
- Sub-module `prim_fifo_wrap_ptr`: one wrap pointer with `clr`, `load`/`load_val` and `incr`, plus the wrap rule. It is instantiated three times, or twice with the feature off.

## Test plan
- Reset and basic fill/drain, Depth=5, thresholds af=4 and ae=1:
  - after 5 writes: `full_o=1`, `depth_o=5`, `wptr_o=0`, and `almost_full_o` rose at the 4th write;
  - after 5 reads: `empty_o=1`.
- Wrap across multiple laps, Depth=5, 13 interleaved write/read pairs: the `wptr_o` sequence is 0,1,2,3,4,0 and so on, the pointer MSB toggles each lap, and `depth_o` stays 1.
- Boundaries:
  - a write when full gives `wr_ack_o=0`, unchanged pointers and `err_o=1`, held until `clr_i`;
  - a read when empty gives `udf`;
  - read and write together when full give `rd_ack_o=1`, `wr_ack_o=0`, `depth_o=4` and `err_o=1`.
- Rewind (macro on), Depth=4:
  - write 4, read 3, commit: `used_o=1`, `full_o=0`;
  - read 1, then rewind: `rptr_o=3`, `depth_o=1`.
  - `rewind_i` together with `incr_rptr_i`: `rd_ack_o=0` and no underflow flag.
- Macro off: `commit_i` and `rewind_i` have no effect, and `used_o` equals `depth_o` every cycle over random traffic.
- Reset mid-traffic with `depth_o=3`: after the edge, all outputs are at their reset values, and a `clr_i` issued in the same cycle has no additional effect.

Source files
------------

// File: rtl/prim_fifo_cnt_pkg.sv
// Shared types and helpers for the FIFO pointer controller: error-cause record,
// pointer width helper and wrap-pointer occupancy arithmetic.
package prim_fifo_cnt_pkg;

    typedef struct packed {
        logic ovf;
        logic udf;
    } err_cause_t;

    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Entries between two wrap pointers; low parts are always below depth.
    function automatic logic [31:0] occupancy(
        input logic        a_msb,
        input logic [31:0] a_low,
        input logic        b_msb,
        input logic [31:0] b_low,
        input logic [31:0] depth
    );
        if (a_msb == b_msb) begin
            return a_low - b_low;
        end
        return depth - b_low + a_low;
    endfunction

endpackage

// File: rtl/prim_fifo_wrap_ptr.sv
// One wrap pointer for an arbitrary-depth FIFO: low part counts 0..Depth-1,
// the extra MSB toggles on every wrap.
module prim_fifo_wrap_ptr #(
    parameter int unsigned Depth = 4,
    parameter int unsigned PtrW  = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic [PtrW:0]   load_val_i,
    input  logic            incr_i,
    output logic [PtrW:0]   ptr_o,
    output logic [PtrW:0]   ptr_incr_o
);

    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

    logic [PtrW:0] ptr_q;

    always_comb begin
        if (ptr_q[PtrW-1:0] == LastIdx) begin
            ptr_incr_o = {~ptr_q[PtrW], {PtrW{1'b0}}};
        end else begin
            ptr_incr_o = ptr_q + {{PtrW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (clr_i) begin
            ptr_q <= '0;
        end else if (load_i) begin
            ptr_q <= load_val_i;
        end else if (incr_i) begin
            ptr_q <= ptr_incr_o;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/prim_fifo_sync_cnt_rw.sv
// Pointer/occupancy controller for arbitrary-depth synchronous FIFOs with
// watermarks and sticky errors; PRIM_FIFO_CNT_REWIND_EN adds commit/rewind reads.
module prim_fifo_sync_cnt_rw
    import prim_fifo_cnt_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter bit          NeverClears = 1'b0,
    localparam int unsigned PtrW       = vbits(Depth),
    localparam int unsigned DepthW     = vbits(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              incr_wptr_i,
    input  logic              incr_rptr_i,
    input  logic              commit_i,
    input  logic              rewind_i,
    input  logic [DepthW-1:0] ae_thresh_i,
    input  logic [DepthW-1:0] af_thresh_i,
    output logic [PtrW-1:0]   wptr_o,
    output logic [PtrW-1:0]   rptr_o,
    output logic [DepthW-1:0] depth_o,
    output logic [DepthW-1:0] used_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              wr_ack_o,
    output logic              rd_ack_o,
    output logic              err_o
);

    logic          clr;
    logic          rewind;
    logic          commit;
    logic [PtrW:0] w_q;
    logic [PtrW:0] r_q;
    logic [PtrW:0] c_q;
    logic [PtrW:0] r_incr;
    logic [PtrW:0] r_next;
    logic [PtrW:0] w_incr_unused;
    logic          unused_inputs;
    err_cause_t    err_q;
    err_cause_t    err_d;

    if (NeverClears) begin : g_no_clr
        assign clr = 1'b0;
    end else begin : g_clr
        assign clr = clr_i;
    end

`ifdef PRIM_FIFO_CNT_REWIND_EN
    assign rewind = rewind_i;
    assign commit = commit_i & ~rewind_i;
`else
    assign rewind = 1'b0;
    assign commit = 1'b0;
`endif

    assign unused_inputs = ^{clr_i, commit_i, rewind_i, w_incr_unused, commit};

    assign wr_ack_o = rst_ni & incr_wptr_i & ~full_o;
    assign rd_ack_o = rst_ni & incr_rptr_i & ~empty_o & ~rewind;
    assign r_next   = rd_ack_o ? r_incr : r_q;

    prim_fifo_wrap_ptr #(
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_wptr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .incr_i     (wr_ack_o),
        .ptr_o      (w_q),
        .ptr_incr_o (w_incr_unused)
    );

    prim_fifo_wrap_ptr #(
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_rptr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr),
        .load_i     (rewind),
        .load_val_i (c_q),
        .incr_i     (rd_ack_o),
        .ptr_o      (r_q),
        .ptr_incr_o (r_incr)
    );

`ifdef PRIM_FIFO_CNT_REWIND_EN
    logic [PtrW:0] c_incr_unused;
    logic          unused_c_incr;

    assign unused_c_incr = ^c_incr_unused;

    // Commit snapshots the read pointer including a read accepted this cycle.
    prim_fifo_wrap_ptr #(
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_cptr (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr),
        .load_i     (commit),
        .load_val_i (r_next),
        .incr_i     (1'b0),
        .ptr_o      (c_q),
        .ptr_incr_o (c_incr_unused)
    );
`else
    logic unused_r_next;

    assign c_q           = r_q;
    assign unused_r_next = ^r_next;
`endif

    assign depth_o = DepthW'(occupancy(w_q[PtrW], 32'(w_q[PtrW-1:0]),
                                       r_q[PtrW], 32'(r_q[PtrW-1:0]), Depth));
    assign used_o  = DepthW'(occupancy(w_q[PtrW], 32'(w_q[PtrW-1:0]),
                                       c_q[PtrW], 32'(c_q[PtrW-1:0]), Depth));

    assign wptr_o         = w_q[PtrW-1:0];
    assign rptr_o         = r_q[PtrW-1:0];
    assign empty_o        = (w_q == r_q);
    assign full_o         = (w_q == (c_q ^ {1'b1, {PtrW{1'b0}}}));
    assign almost_full_o  = (used_o >= af_thresh_i);
    assign almost_empty_o = (depth_o <= ae_thresh_i);

    always_comb begin
        err_d     = err_q;
        err_d.ovf = err_q.ovf | (incr_wptr_i & full_o);
        err_d.udf = err_q.udf | (incr_rptr_i & empty_o & ~rewind);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= '0;
        end else if (clr) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q.ovf | err_q.udf;

endmodule

// File: tb/tb_prim_fifo_sync_cnt_rw.sv
// Directed bench: Depth=5 instance for fill/wrap/boundary/reset, Depth=4
// instance for commit/rewind (or its absence without PRIM_FIFO_CNT_REWIND_EN).
module tb_prim_fifo_sync_cnt_rw;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       clr_a, wr_a, rd_a, cm_a, rw_a;
    logic [2:0] ae_a, af_a;
    logic [2:0] wptr_a, rptr_a, depth_a, used_a;
    logic       full_a, empty_a, afl_a, ael_a, wack_a, rack_a, err_a;

    logic       clr_b, wr_b, rd_b, cm_b, rw_b;
    logic [2:0] ae_b, af_b;
    logic [1:0] wptr_b, rptr_b;
    logic [2:0] depth_b, used_b;
    logic       full_b, empty_b, afl_b, ael_b, wack_b, rack_b, err_b;

    int vecs = 0;
    int errs = 0;

    prim_fifo_sync_cnt_rw #(.Depth(5), .NeverClears(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_a),
        .incr_wptr_i(wr_a), .incr_rptr_i(rd_a), .commit_i(cm_a), .rewind_i(rw_a),
        .ae_thresh_i(ae_a), .af_thresh_i(af_a),
        .wptr_o(wptr_a), .rptr_o(rptr_a), .depth_o(depth_a), .used_o(used_a),
        .full_o(full_a), .empty_o(empty_a), .almost_full_o(afl_a), .almost_empty_o(ael_a),
        .wr_ack_o(wack_a), .rd_ack_o(rack_a), .err_o(err_a)
    );

    prim_fifo_sync_cnt_rw #(.Depth(4), .NeverClears(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_b),
        .incr_wptr_i(wr_b), .incr_rptr_i(rd_b), .commit_i(cm_b), .rewind_i(rw_b),
        .ae_thresh_i(ae_b), .af_thresh_i(af_b),
        .wptr_o(wptr_b), .rptr_o(rptr_b), .depth_o(depth_b), .used_o(used_b),
        .full_o(full_b), .empty_o(empty_b), .almost_full_o(afl_b), .almost_empty_o(ael_b),
        .wr_ack_o(wack_b), .rd_ack_o(rack_b), .err_o(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_a(input logic w, input logic r, input logic c);
        wr_a = w; rd_a = r; clr_a = c;
        tick();
        wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic cyc_b(input logic w, input logic r, input logic cm, input logic rw);
        wr_b = w; rd_b = r; cm_b = cm; rw_b = rw;
        tick();
        wr_b = 1'b0; rd_b = 1'b0; cm_b = 1'b0; rw_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ae_a = 3'd1; af_a = 3'd4;
        ae_b = 3'd0; af_b = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
        // {empty, full, err, almost_empty, almost_full}
        vecs++; if ({empty_a, full_a, err_a, ael_a, afl_a} !== 5'b10010) begin errs++;
            $display("FAIL reset_flags_a: got %b want 10010", {empty_a, full_a, err_a, ael_a, afl_a}); end
        vecs++; if ({wptr_a, rptr_a, depth_a, used_a} !== 12'h000) begin errs++;
            $display("FAIL reset_counts_a: got %h want 000", {wptr_a, rptr_a, depth_a, used_a}); end
        vecs++; if ({empty_b, full_b, err_b, ael_b, afl_b} !== 5'b10011) begin errs++;
            $display("FAIL reset_flags_b_af0: got %b want 10011", {empty_b, full_b, err_b, ael_b, afl_b}); end
        af_b = 3'd4;
        #1;
        vecs++; if (afl_b !== 1'b0) begin errs++;
            $display("FAIL reset_af_b_thr4: got %b want 0", afl_b); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            wr_a = 1'b1;
            #1;
            vecs++; if (wack_a !== 1'b1) begin errs++;
                $display("FAIL fill_wack[%0d]: got %b want 1", i, wack_a); end
            tick();
            wr_a = 1'b0;
            vecs++; if ({afl_a, depth_a} !== {(i >= 4) ? 1'b1 : 1'b0, 3'(i)}) begin errs++;
                $display("FAIL fill_af_depth[%0d]: got af=%b depth=%0d want af=%b depth=%0d",
                         i, afl_a, depth_a, (i >= 4), i); end
        end
        vecs++; if ({full_a, depth_a, wptr_a} !== {1'b1, 3'd5, 3'd0}) begin errs++;
            $display("FAIL fill_end: got full=%b depth=%0d wptr=%0d want 1 5 0", full_a, depth_a, wptr_a); end
        for (int i = 1; i <= 5; i++) begin
            rd_a = 1'b1;
            #1;
            vecs++; if (rack_a !== 1'b1) begin errs++;
                $display("FAIL drain_rack[%0d]: got %b want 1", i, rack_a); end
            tick();
            rd_a = 1'b0;
        end
        vecs++; if ({empty_a, ael_a, depth_a, rptr_a, err_a} !== {1'b1, 1'b1, 3'd0, 3'd0, 1'b0}) begin errs++;
            $display("FAIL drain_end: got empty=%b ae=%b depth=%0d rptr=%0d err=%b want 1 1 0 0 0",
                     empty_a, ael_a, depth_a, rptr_a, err_a); end
    endtask

    task automatic test_boundaries();
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b0, 1'b0);
        wr_a = 1'b1;
        #1;
        vecs++; if (wack_a !== 1'b0) begin errs++;
            $display("FAIL ovf_wack: got %b want 0", wack_a); end
        tick();
        wr_a = 1'b0;
        vecs++; if ({err_a, depth_a, wptr_a, rptr_a} !== {1'b1, 3'd5, 3'd0, 3'd0}) begin errs++;
            $display("FAIL ovf_state: got err=%b depth=%0d wptr=%0d rptr=%0d want 1 5 0 0",
                     err_a, depth_a, wptr_a, rptr_a); end
        wr_a = 1'b1; rd_a = 1'b1;
        #1;
        vecs++; if ({rack_a, wack_a} !== 2'b10) begin errs++;
            $display("FAIL full_rw_acks: got %b want 10", {rack_a, wack_a}); end
        tick();
        wr_a = 1'b0; rd_a = 1'b0;
        vecs++; if ({depth_a, err_a, rptr_a, full_a} !== {3'd4, 1'b1, 3'd1, 1'b0}) begin errs++;
            $display("FAIL full_rw_state: got depth=%0d err=%b rptr=%0d full=%b want 4 1 1 0",
                     depth_a, err_a, rptr_a, full_a); end
        tick();
        vecs++; if (err_a !== 1'b1) begin errs++;
            $display("FAIL err_sticky: got %b want 1", err_a); end
        cyc_a(1'b0, 1'b0, 1'b1);
        vecs++; if ({empty_a, full_a, err_a, depth_a, wptr_a, rptr_a} !== {3'b100, 9'd0}) begin errs++;
            $display("FAIL clr_state: got %b want 100000000000", {empty_a, full_a, err_a, depth_a, wptr_a, rptr_a}); end
        rd_a = 1'b1;
        #1;
        vecs++; if (rack_a !== 1'b0) begin errs++;
            $display("FAIL udf_rack: got %b want 0", rack_a); end
        tick();
        rd_a = 1'b0;
        vecs++; if ({err_a, rptr_a, empty_a} !== {1'b1, 3'd0, 1'b1}) begin errs++;
            $display("FAIL udf_state: got err=%b rptr=%0d empty=%b want 1 0 1", err_a, rptr_a, empty_a); end
        cyc_a(1'b0, 1'b0, 1'b1);
        wr_a = 1'b1; rd_a = 1'b1;
        #1;
        vecs++; if ({rack_a, wack_a} !== 2'b01) begin errs++;
            $display("FAIL empty_rw_acks: got %b want 01", {rack_a, wack_a}); end
        tick();
        wr_a = 1'b0; rd_a = 1'b0;
        vecs++; if ({depth_a, err_a} !== {3'd1, 1'b1}) begin errs++;
            $display("FAIL empty_rw_state: got depth=%0d err=%b want 1 1", depth_a, err_a); end
        cyc_a(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        int cnt;
        cyc_a(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            cyc_a(1'b1, 1'b1, 1'b0);
            cnt = 1 + k;
            vecs++; if ({dut_a.u_wptr.ptr_o[3], wptr_a, depth_a, rptr_a} !==
                        {1'((cnt / 5) % 2), 3'(cnt % 5), 3'd1, 3'((cnt - 1) % 5)}) begin errs++;
                $display("FAIL wrap[%0d]: got msb=%b wptr=%0d depth=%0d rptr=%0d want %0d %0d 1 %0d",
                         k, dut_a.u_wptr.ptr_o[3], wptr_a, depth_a, rptr_a,
                         (cnt / 5) % 2, cnt % 5, (cnt - 1) % 5); end
        end
        cyc_a(1'b0, 1'b0, 1'b1);
    endtask

`ifdef PRIM_FIFO_CNT_REWIND_EN
    task automatic test_rewind();
        for (int i = 0; i < 4; i++) cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
        vecs++; if (full_b !== 1'b1) begin errs++;
            $display("FAIL rw_fill: got full=%b want 1", full_b); end
        cyc_b(1'b0, 1'b1, 1'b0, 1'b0);
        cyc_b(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++; if ({used_b, full_b} !== {3'd4, 1'b1}) begin errs++;
            $display("FAIL rw_uncommitted: got used=%0d full=%b want 4 1", used_b, full_b); end
        cyc_b(1'b0, 1'b1, 1'b1, 1'b0);
        vecs++; if ({used_b, full_b, depth_b, rptr_b} !== {3'd1, 1'b0, 3'd1, 2'd3}) begin errs++;
            $display("FAIL rw_commit: got used=%0d full=%b depth=%0d rptr=%0d want 1 0 1 3",
                     used_b, full_b, depth_b, rptr_b); end
        cyc_b(1'b0, 1'b1, 1'b0, 1'b0);
        vecs++; if ({depth_b, rptr_b, used_b, empty_b} !== {3'd0, 2'd0, 3'd1, 1'b1}) begin errs++;
            $display("FAIL rw_read_after: got depth=%0d rptr=%0d used=%0d empty=%b want 0 0 1 1",
                     depth_b, rptr_b, used_b, empty_b); end
        cyc_b(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if ({rptr_b, depth_b} !== {2'd3, 3'd1}) begin errs++;
            $display("FAIL rw_rewind: got rptr=%0d depth=%0d want 3 1", rptr_b, depth_b); end
        rd_b = 1'b1; rw_b = 1'b1;
        #1;
        vecs++; if (rack_b !== 1'b0) begin errs++;
            $display("FAIL rw_rd_blocked: got %b want 0", rack_b); end
        tick();
        rd_b = 1'b0; rw_b = 1'b0;
        vecs++; if ({err_b, rptr_b, depth_b} !== {1'b0, 2'd3, 3'd1}) begin errs++;
            $display("FAIL rw_no_udf: got err=%b rptr=%0d depth=%0d want 0 3 1", err_b, rptr_b, depth_b); end
    endtask
`else
    task automatic test_macro_off();
        int  cnt;
        logic em, w, r, cm, rw;
        cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
        cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
        cyc_b(1'b0, 1'b1, 1'b1, 1'b0);
        vecs++; if ({depth_b, used_b} !== {3'd1, 3'd1}) begin errs++;
            $display("FAIL off_read: got depth=%0d used=%0d want 1 1", depth_b, used_b); end
        rd_b = 1'b1; rw_b = 1'b1;
        #1;
        vecs++; if (rack_b !== 1'b1) begin errs++;
            $display("FAIL off_rd_not_blocked: got %b want 1", rack_b); end
        tick();
        rd_b = 1'b0; rw_b = 1'b0;
        vecs++; if ({depth_b, used_b, rptr_b, err_b} !== {3'd0, 3'd0, 2'd2, 1'b0}) begin errs++;
            $display("FAIL off_rewind_ignored: got depth=%0d used=%0d rptr=%0d err=%b want 0 0 2 0",
                     depth_b, used_b, rptr_b, err_b); end
        cyc_b(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++; if (rptr_b !== 2'd2) begin errs++;
            $display("FAIL off_rewind_alone: got rptr=%0d want 2", rptr_b); end
        cnt = 0; em = 1'b0;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
            cm = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
            em = em | (w && cnt == 4) | (r && cnt == 0);
            cnt = cnt + ((w && cnt < 4) ? 1 : 0) - ((r && cnt > 0) ? 1 : 0);
            cyc_b(w, r, cm, rw);
            vecs++; if ({depth_b, used_b, err_b} !== {3'(cnt), 3'(cnt), em}) begin errs++;
                $display("FAIL off_rand[%0d]: got depth=%0d used=%0d err=%b want %0d %0d %b",
                         i, depth_b, used_b, err_b, cnt, cnt, em); end
        end
    endtask
`endif

    task automatic test_mid_reset();
        cyc_a(1'b0, 1'b0, 1'b1);
        cyc_a(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 1'b0, 1'b0);
        vecs++; if ({depth_a, err_a} !== {3'd3, 1'b1}) begin errs++;
            $display("FAIL mid_pre: got depth=%0d err=%b want 3 1", depth_a, err_a); end
        rst_n = 1'b0; wr_a = 1'b1; rd_a = 1'b1; clr_a = 1'b1;
        #1;
        vecs++; if ({wack_a, rack_a} !== 2'b00) begin errs++;
            $display("FAIL mid_acks: got %b want 00", {wack_a, rack_a}); end
        tick();
        rst_n = 1'b1; wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
        #1;
        vecs++; if ({empty_a, full_a, err_a, ael_a, afl_a} !== 5'b10010) begin errs++;
            $display("FAIL mid_flags: got %b want 10010", {empty_a, full_a, err_a, ael_a, afl_a}); end
        vecs++; if ({wptr_a, rptr_a, depth_a, used_a} !== 12'h000) begin errs++;
            $display("FAIL mid_counts: got %h want 000", {wptr_a, rptr_a, depth_a, used_a}); end
    endtask

    initial begin
        clr_a = 1'b0; wr_a = 1'b0; rd_a = 1'b0; cm_a = 1'b0; rw_a = 1'b0;
        clr_b = 1'b0; wr_b = 1'b0; rd_b = 1'b0; cm_b = 1'b0; rw_b = 1'b0;
        ae_a = 3'd1; af_a = 3'd4; ae_b = 3'd0; af_b = 3'd0;
        rst_n = 1'b0;
        test_reset();
        test_fill_drain();
        test_boundaries();
        test_wrap();
`ifdef PRIM_FIFO_CNT_REWIND_EN
        test_rewind();
`else
        test_macro_off();
`endif
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
